// File: rtl/ekf_ram_pkg.sv
// Shared constants and FSM encoding for the RAM burst master.
package ekf_ram_pkg;

    localparam int unsigned DW_DEFAULT = 16;
    localparam int unsigned AW_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry read buffer with a flow-through path when empty.
// The read data therefore reaches rd_valid in the same cycle that it leaves the RAM.
module rd_skid_buf #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          head;
    logic          tail;
    logic          push;
    logic          pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0) || in_valid;
    assign out_data  = (count != 2'd0) ? mem[head] :
                       (in_valid ? in_data : '0);
    assign tail      = head ^ count[0];
    // A word is stored only when it cannot leave through the bypass path.
    assign push      = in_valid && in_ready && !((count == 2'd0) && out_ready);
    assign pop       = out_ready && (count != 2'd0);

    // Occupancy and head pointer; reset empties the buffer.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            head  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage array; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= in_data;
        end
    end

endmodule

// File: rtl/ram_burst_master.sv
// Burst master that turns write/read burst commands into accesses to a
// single-port synchronous RAM, with streaming write and read data ports.
module ram_burst_master
    import ekf_ram_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW-1:0] cmd_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          done
);

    localparam int unsigned CW = AW + 1;

    state_t        state;
    logic [AW-1:0] addr;
    logic [CW-1:0] issue_left;
    logic [CW-1:0] beat_left;
    logic          inflight;
    logic [1:0]    buf_count;
    logic          buf_in_ready;
    logic          wr_fire;
    logic          rd_issue;
    logic          rd_fire;

    // cmd_ready is gated by reset so it is low during reset and high right after release.
    assign cmd_ready = sys_rst && (state == IDLE);
    assign wr_ready  = (state == WRITE);
    assign done      = (state == DONE);
    assign wr_fire   = wr_ready && wr_valid;
    assign rd_fire   = rd_valid && rd_ready;

    // Never exceed two words between the in-flight read and the buffer.
    assign rd_issue  = (state == READ) && (issue_left != '0) && buf_in_ready &&
                       ((buf_count + {1'b0, inflight}) < 2'd2);

    assign ram_en    = wr_fire || rd_issue;
    assign ram_we    = wr_fire;
    assign ram_addr  = ram_en ? addr : '0;
    assign ram_din   = wr_fire ? wr_data : '0;

    rd_skid_buf #(
        .DW(DW)
    ) u_rd_buf (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .in_valid  (inflight),
        .in_ready  (buf_in_ready),
        .in_data   (ram_dout),
        .out_valid (rd_valid),
        .out_ready (rd_ready),
        .out_data  (rd_data),
        .count     (buf_count)
    );

    // Burst sequencing: command latch, address/counter stepping and completion.
    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state      <= IDLE;
            addr       <= '0;
            issue_left <= '0;
            beat_left  <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= rd_issue;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr       <= cmd_base;
                        issue_left <= {1'b0, cmd_len} + CW'(1);
                        beat_left  <= {1'b0, cmd_len} + CW'(1);
                        state      <= cmd_we ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        addr       <= addr + AW'(1);
                        issue_left <= issue_left - CW'(1);
                        if (issue_left == CW'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        addr       <= addr + AW'(1);
                        issue_left <= issue_left - CW'(1);
                    end
                    if (rd_fire) begin
                        beat_left <= beat_left - CW'(1);
                        if (beat_left == CW'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_burst_master.sv
// Scoreboard bench for ram_burst_master with a behavioural synchronous RAM.
module tb_ram_burst_master;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk;
    logic          sys_rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_base;
    logic [AW-1:0] cmd_len;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          done;

    logic [DW-1:0] ram   [DEPTH];
    logic [DW-1:0] model [DEPTH];

    logic [AW-1:0] exp_addr_q [$];
    logic [DW-1:0] exp_data_q [$];

    int checks;
    int failures;

    ram_burst_master #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read data one cycle after request, zero otherwise.
    always @(posedge clk) begin
        if (ram_en === 1'b1 && ram_we === 1'b1) begin
            ram[ram_addr] <= ram_din;
        end
        ram_dout <= (ram_en === 1'b1 && ram_we === 1'b0) ? ram[ram_addr] : '0;
    end

    task automatic start_cmd(input logic we, input logic [AW-1:0] base, input logic [AW-1:0] len);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_base  = base;
        cmd_len   = len;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_idle got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b0 || wr_ready !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0 ||
            ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_din !== '0 || rd_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs cmd_ready=%b wr_ready=%b rd_valid=%b done=%b ram_en=%b exp all 0",
                     cmd_ready, wr_ready, rd_valid, done, ram_en);
        end
        @(negedge clk);
        sys_rst = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_cmd_ready got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_write(input string name, input logic [AW-1:0] base, input logic [AW-1:0] len,
                              input logic [DW-1:0] d0, input bit gaps);
        logic [AW-1:0] a;
        int n;
        for (int i = 0; i <= int'(len); i++) begin
            a = base + AW'(i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(d0 + DW'(i));
            model[a] = d0 + DW'(i);
        end
        start_cmd(1'b1, base, len);
        n = 0;
        while (exp_addr_q.size() != 0 && n < 200) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            n++;
            wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data  = exp_data_q[0];
            #1;
            checks++;
            if (wr_ready !== 1'b1 || done !== 1'b0 || cmd_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s_wr_ready wr_ready=%b done=%b cmd_ready=%b exp 1/0/0", name, wr_ready, done, cmd_ready);
            end
            checks++;
            if (wr_valid) begin
                if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== exp_addr_q[0] || ram_din !== exp_data_q[0]) begin
                    failures++;
                    $display("FAIL %s_write en=%b we=%b addr=%0d exp=%0d din=%h exp=%h",
                             name, ram_en, ram_we, ram_addr, exp_addr_q[0], ram_din, exp_data_q[0]);
                end
                void'(exp_addr_q.pop_front());
                void'(exp_data_q.pop_front());
            end else if (ram_en !== 1'b0) begin
                failures++;
                $display("FAIL %s_write_idle ram_en=%b exp=0", name, ram_en);
            end
        end
        @(negedge clk);
        wr_valid = 1'b0;
        wr_data  = '0;
        #1;
        checks++;
        if (exp_addr_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout writes_left=%0d exp=0", name, exp_addr_q.size());
            exp_addr_q.delete();
            exp_data_q.delete();
        end
        checks++;
        if (done !== 1'b1 || wr_ready !== 1'b0 || ram_en !== 1'b0 || ram_addr !== '0 || ram_din !== '0) begin
            failures++;
            $display("FAIL %s_done done=%b wr_ready=%b ram_en=%b addr=%0d exp 1/0/0/0", name, done, wr_ready, ram_en, ram_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_idle done=%b cmd_ready=%b exp 0/1", name, done, cmd_ready);
        end
    endtask

    // mode 0: rd_ready high; 1: pattern 1,0,0,1; 2: random.
    task automatic test_read(input string name, input logic [AW-1:0] base, input logic [AW-1:0] len, input int mode);
        logic [AW-1:0] a;
        logic          prev_valid;
        logic          prev_ready;
        logic [DW-1:0] prev_data;
        int n, issued, consumed, first_issue, last_hs, exp_cyc;
        for (int i = 0; i <= int'(len); i++) begin
            a = base + AW'(i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(model[a]);
        end
        start_cmd(1'b0, base, len);
        n = 0; issued = 0; consumed = 0; first_issue = -1; last_hs = -1;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
        while (exp_data_q.size() != 0 && n < 300) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            n++;
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = ((n % 4) == 1) || ((n % 4) == 0);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (ram_en === 1'b1) begin
                issued++;
                if (first_issue < 0) first_issue = n;
                checks++;
                if (ram_we !== 1'b0 || exp_addr_q.size() == 0 || ram_addr !== exp_addr_q[0]) begin
                    failures++;
                    $display("FAIL %s_read_addr we=%b addr=%0d exp=%0d left=%0d", name, ram_we, ram_addr,
                             (exp_addr_q.size() != 0) ? exp_addr_q[0] : '0, exp_addr_q.size());
                end
                if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
            end
            checks++;
            if (issued - consumed > 2) begin
                failures++;
                $display("FAIL %s_outstanding got=%0d exp<=2", name, issued - consumed);
            end
            if (prev_valid && !prev_ready) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
                    failures++;
                    $display("FAIL %s_stall_hold rd_valid=%b data=%h exp=1/%h", name, rd_valid, rd_data, prev_data);
                end
            end
            if (rd_valid === 1'b1 && rd_ready) begin
                checks++;
                if (rd_data !== exp_data_q[0]) begin
                    failures++;
                    $display("FAIL %s_rd_data got=%h exp=%h", name, rd_data, exp_data_q[0]);
                end
                if (mode == 0) begin
                    exp_cyc = (consumed == 0) ? first_issue + 1 : last_hs + 1;
                    checks++;
                    if (n != exp_cyc) begin
                        failures++;
                        $display("FAIL %s_latency cycle=%0d exp=%0d", name, n, exp_cyc);
                    end
                end
                void'(exp_data_q.pop_front());
                consumed++;
                last_hs = n;
            end
            prev_valid = rd_valid;
            prev_ready = rd_ready;
            prev_data  = rd_data;
        end
        @(negedge clk);
        rd_ready = 1'b0;
        #1;
        checks++;
        if (exp_data_q.size() != 0 || exp_addr_q.size() != 0 || issued != int'(len) + 1) begin
            failures++;
            $display("FAIL %s_count issued=%0d exp=%0d words_left=%0d", name, issued, int'(len) + 1, exp_data_q.size());
            exp_addr_q.delete();
            exp_data_q.delete();
        end
        checks++;
        if (done !== 1'b1 || rd_valid !== 1'b0 || ram_en !== 1'b0) begin
            failures++;
            $display("FAIL %s_done done=%b rd_valid=%b ram_en=%b exp 1/0/0", name, done, rd_valid, ram_en);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_idle done=%b cmd_ready=%b exp 0/1", name, done, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        bit got_first;
        start_cmd(1'b0, 4'd8, 4'd3);
        n = 0;
        got_first = 1'b0;
        while (!got_first && n < 20) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            rd_ready  = 1'b1;
            n++;
            #1;
            if (rd_valid === 1'b1) begin
                got_first = 1'b1;
                checks++;
                if (rd_data !== model[8]) begin
                    failures++;
                    $display("FAIL abort_first_word got=%h exp=%h", rd_data, model[8]);
                end
            end
        end
        checks++;
        if (!got_first) begin
            failures++;
            $display("FAIL abort_timeout rd_valid=%b exp=1", rd_valid);
        end
        @(negedge clk);
        sys_rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0 || wr_ready !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0 || rd_data !== '0 ||
            ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_din !== '0) begin
            failures++;
            $display("FAIL abort_outputs cmd_ready=%b rd_valid=%b done=%b ram_en=%b rd_data=%h exp all 0",
                     cmd_ready, rd_valid, done, ram_en, rd_data);
        end
        repeat (2) begin
            @(negedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL abort_hold done=%b rd_valid=%b exp 0/0", done, rd_valid);
            end
        end
        @(negedge clk);
        sys_rst = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_release cmd_ready=%b rd_valid=%b exp 1/0", cmd_ready, rd_valid);
        end
        repeat (3) begin
            @(negedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || rd_valid !== 1'b0 || ram_en !== 1'b0) begin
                failures++;
                $display("FAIL abort_after done=%b rd_valid=%b ram_en=%b exp 0/0/0", done, rd_valid, ram_en);
            end
        end
        rd_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        test_reset();
        test_write("wr_a1", 4'd3, 4'd2, 16'h00A1, 1'b0);
        test_read("rd_a1", 4'd3, 4'd2, 0);
        test_write("wr_full", 4'd0, 4'd15, 16'h1000, 1'b0);
        test_read("rd_wrap", 4'd14, 4'd3, 0);
        test_read("rd_stall", 4'd5, 4'd7, 1);
        test_write("wr_gaps", 4'd10, 4'd9, 16'h2B00, 1'b1);
        test_read("rd_random", 4'd9, 4'd15, 2);
        test_reset_mid_burst();
        test_read("rd_after_abort", 4'd8, 4'd3, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
